// File: rtl/matrix_row_fetcher_pkg.sv
// Shared types and defaults for the matrix row fetcher
// and the ROM slave wrapper it reads from.
package matrix_row_fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        PUSH
    } fetch_state_t;

    localparam int unsigned DEF_NUM_ROWS    = 8;
    localparam int unsigned DEF_DATA_W      = 64;
    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_BASE_ADDR   = 0;
    localparam int unsigned DEF_ADDR_STRIDE = 1;
    localparam int unsigned DEF_TIMEOUT     = 255;

    // Counter width for n distinct values, never below one bit.
    function automatic int cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_IDX_W = cnt_w(DEF_NUM_ROWS);
    localparam int DEF_TMR_W = cnt_w(DEF_TIMEOUT + 1);

endpackage

// File: rtl/matrix_row_fetcher.sv
// Avalon-MM read master: fetches NUM_ROWS rows one read at a time
// and streams each row downstream over valid/ready.
module matrix_row_fetcher
    import matrix_row_fetcher_pkg::*;
#(
    parameter int unsigned NUM_ROWS       = DEF_NUM_ROWS,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned BASE_ADDR      = DEF_BASE_ADDR,
    parameter int unsigned ADDR_STRIDE    = DEF_ADDR_STRIDE,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT,
    localparam int IDX_W = cnt_w(NUM_ROWS),
    localparam int TMR_W = cnt_w(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] row_data,
    output logic [IDX_W-1:0]  row_idx,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ADDR_STRIDE);
    localparam logic [IDX_W-1:0]  LAST   = IDX_W'(NUM_ROWS - 1);
    localparam logic [TMR_W-1:0]  T_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [IDX_W-1:0] row_cnt;
    logic [TMR_W-1:0] timer;

    logic go;
    logic acc;
    logic got;
    logic tmo;
    logic tick;
    logic pop;
    logic last;

    assign go   = (state_q == IDLE) && start;
    assign acc  = (state_q == REQ) && avm_read && !avm_waitrequest;
    assign got  = (state_q == WAIT_DATA) && avm_readdatavalid;
    assign tmo  = (state_q == WAIT_DATA) && !avm_readdatavalid
                  && (timer == T_LAST);
    assign tick = (state_q == WAIT_DATA) && !avm_readdatavalid
                  && (timer != T_LAST);
    assign pop  = (state_q == PUSH) && row_valid && row_ready;
    assign last = (row_cnt == LAST);
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:      if (go) state_d = REQ;
                REQ:       if (acc) state_d = WAIT_DATA;
                WAIT_DATA: begin
                    if (got) begin
                        state_d = PUSH;
                    end else if (tmo) begin
                        state_d = IDLE;
                    end
                end
                PUSH:      if (pop) state_d = last ? IDLE : REQ;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Strobes are mutually exclusive because each is qualified by state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_address <= BASE;
            avm_read    <= 1'b0;
            row_data    <= '0;
            row_idx     <= '0;
            row_valid   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            row_cnt     <= '0;
            timer       <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                avm_read  <= 1'b0;
                row_valid <= 1'b0;
            end else begin
                unique case (1'b1)
                    go: begin
                        row_cnt     <= '0;
                        error       <= 1'b0;
                        avm_address <= BASE;
                        avm_read    <= 1'b1;
                    end
                    acc: begin
                        avm_read <= 1'b0;
                        timer    <= '0;
                    end
                    tick: begin
                        timer <= timer + 1'b1;
                    end
                    tmo: begin
                        error <= 1'b1;
                    end
                    got: begin
                        row_data  <= avm_readdata;
                        row_idx   <= row_cnt;
                        row_valid <= 1'b1;
                    end
                    pop: begin
                        row_valid <= 1'b0;
                        if (last) begin
                            done <= 1'b1;
                        end else begin
                            row_cnt     <= row_cnt + 1'b1;
                            avm_address <= avm_address + STRIDE;
                            avm_read    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
